// File: rtl/counter60_down.sv
`default_nettype none
// ============================================================================
// Module      : counter60_down
// Description : BCD mod-60 countdown timer. It stops at 00 and raises done, or
//               it reloads and pulses bout for cascading into a minutes stage.
// Revision    : 1.0 - initial release
// ============================================================================
module counter60_down #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] cnt,
    output logic       bout,
    output logic       busy,
    output logic       done,
    output logic       load_err
);

    localparam logic [7:0] c_ZERO        = 8'h00;
    localparam logic [7:0] c_ONE         = 8'h01;
    localparam logic [7:0] c_RELOAD_INIT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] r_reload;
    logic [7:0] w_reload_nxt;
    logic       r_bout;
    logic       w_bout_nxt;
    logic       r_busy;
    logic       r_done;
    logic       r_load_err;
    logic       w_load_err_nxt;
    logic       w_load_ok;
    logic [7:0] w_cnt_dec;

    assign w_load_ok = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd5);

    // Units underflow wraps to 9 and borrows from the tens digit.
    assign w_cnt_dec = (r_cnt[3:0] != 4'd0) ? {r_cnt[7:4], r_cnt[3:0] - 4'd1}
                                            : {r_cnt[7:4] - 4'd1, 4'd9};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_reload_nxt   = r_reload;
        w_bout_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;

        if (load && (r_state != ST_RUN)) begin
            if (w_load_ok) begin
                w_cnt_nxt    = load_val;
                w_reload_nxt = load_val;
                w_state_nxt  = ST_IDLE;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && ((r_cnt != c_ZERO) || AUTO_RELOAD)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start outranks stop, so start+stop keeps counting
                    if (stop && !start) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (EN) begin
                        if (r_cnt == c_ZERO) begin
                            if (AUTO_RELOAD) begin
                                w_cnt_nxt  = r_reload;
                                w_bout_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else if ((r_cnt == c_ONE) && !AUTO_RELOAD) begin
                            w_cnt_nxt   = c_ZERO;
                            w_bout_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_cnt_nxt = w_cnt_dec;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        w_cnt_nxt   = r_reload;
                        w_state_nxt = (r_reload == c_ZERO) ? ST_DONE : ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= c_ZERO;
            r_reload   <= c_RELOAD_INIT;
            r_bout     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_reload   <= w_reload_nxt;
            r_bout     <= w_bout_nxt;
            r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
            r_done     <= (w_state_nxt == ST_DONE);
            r_load_err <= w_load_err_nxt;
        end
    end

    assign cnt      = r_cnt;
    assign bout     = r_bout;
    assign busy     = r_busy;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule
`default_nettype wire
